butterfly_stage_cplx: RTL and testbench

- Parametrised complex radix-2 DIT butterfly for the in-place FFT datapath: X = A + W·B, Y = A − W·B.
- Generalises the fixed real add/sub stage:
  - real/imag operands
  - runtime twiddle multiply
  - selectable per-beat ÷2 scaling
  - round-half-up
  - saturation with a sticky overflow flag
  - full AXI-stream backpressure across a 3-stage pipeline.
- Sits between the operand-fetch unit (BRAM read + twiddle ROM) and the write-back unit; one butterfly per beat.

---
 rtl/butterfly_stage_cplx_if.sv | 45 ++++
 rtl/butterfly_stage_cplx.sv | 156 +++++++++++++++
 tb/tb_butterfly_stage_cplx.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/butterfly_stage_cplx_if.sv
`default_nettype none
// ============================================================================
// Module   : butterfly_stage_cplx_if
// Purpose  : Operand/result stream bundle for the complex radix-2 butterfly.
// Revision : 1.0
// ============================================================================
interface butterfly_stage_cplx_if #(
   parameter int WIDTH    = 16,
   parameter int TW_WIDTH = 16
);
   logic                       s_tvalid;
   logic                       s_tready;
   logic                       s_tlast;
   logic signed [WIDTH-1:0]    a_re;
   logic signed [WIDTH-1:0]    a_im;
   logic signed [WIDTH-1:0]    b_re;
   logic signed [WIDTH-1:0]    b_im;
   logic signed [TW_WIDTH-1:0] w_re;
   logic signed [TW_WIDTH-1:0] w_im;
   logic                       scale_i;
   logic                       m_tvalid;
   logic                       m_tready;
   logic                       m_tlast;
   logic signed [WIDTH-1:0]    x_re;
   logic signed [WIDTH-1:0]    x_im;
   logic signed [WIDTH-1:0]    y_re;
   logic signed [WIDTH-1:0]    y_im;
   logic                       ovf_o;
   logic                       ovf_clr_i;

   // Upstream/downstream environment side
   modport master (
      output s_tvalid, s_tlast, a_re, a_im, b_re, b_im, w_re, w_im, scale_i,
      output m_tready, ovf_clr_i,
      input  s_tready, m_tvalid, m_tlast, x_re, x_im, y_re, y_im, ovf_o
   );

   // Butterfly side
   modport slave (
      input  s_tvalid, s_tlast, a_re, a_im, b_re, b_im, w_re, w_im, scale_i,
      input  m_tready, ovf_clr_i,
      output s_tready, m_tvalid, m_tlast, x_re, x_im, y_re, y_im, ovf_o
   );
endinterface
`default_nettype wire

// File: rtl/butterfly_stage_cplx.sv
`default_nettype none
// ============================================================================
// Module   : butterfly_stage_cplx
// Purpose  : 3-stage complex DIT butterfly X = A + W*B, Y = A - W*B with
//            optional /2 scaling, round-half-up and sticky saturation flag.
// Revision : 1.0
// ============================================================================
module butterfly_stage_cplx #(
   parameter int WIDTH    = 16,
   parameter int TW_WIDTH = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   butterfly_stage_cplx_if.slave bus
);
   localparam int PW = WIDTH + TW_WIDTH;
   localparam int SW = PW + 1;
   localparam int XW = WIDTH + 2;

   localparam logic signed [SW-1:0] c_RND = {{PW{1'b0}}, 1'b1} << (TW_WIDTH - 2);
   localparam logic signed [XW-1:0] c_ONE = {{(WIDTH+1){1'b0}}, 1'b1};
   localparam logic signed [XW-1:0] c_MAX = {3'b000, {(WIDTH-1){1'b1}}};
   localparam logic signed [XW-1:0] c_MIN = {3'b111, {(WIDTH-1){1'b0}}};

   // Optional halving (round-half-up), then clamp; MSB of result = saturated
   function automatic logic [WIDTH:0] f_post(input logic signed [XW-1:0] v,
                                             input logic sc);
      logic signed [XW-1:0] r;
      r = sc ? ((v + c_ONE) >>> 1) : v;
      if (r > c_MAX)
         return {1'b1, c_MAX[WIDTH-1:0]};
      else if (r < c_MIN)
         return {1'b1, c_MIN[WIDTH-1:0]};
      else
         return {1'b0, r[WIDTH-1:0]};
   endfunction

   logic                    w_en;

   logic                    r1_valid, r1_last, r1_scale;
   logic signed [WIDTH-1:0] r1_a_re, r1_a_im;
   logic signed [PW-1:0]    r1_p_rr, r1_p_ii, r1_p_ri, r1_p_ir;

   logic                    r2_valid, r2_last, r2_scale;
   logic signed [WIDTH-1:0] r2_a_re, r2_a_im;
   logic signed [WIDTH:0]   r2_t_re, r2_t_im;

   logic                    r3_valid, r3_last;
   logic signed [WIDTH-1:0] r3_x_re, r3_x_im, r3_y_re, r3_y_im;
   logic                    r_ovf;

   logic signed [PW-1:0]    w_p_rr, w_p_ii, w_p_ri, w_p_ir;
   logic signed [SW-1:0]    w_rnd_re, w_rnd_im;
   logic signed [XW-1:0]    w_x_re, w_x_im, w_y_re, w_y_im;
   logic        [WIDTH:0]   w_px_re, w_px_im, w_py_re, w_py_im;
   logic                    w_sat;
   logic                    w_unused;

   assign w_en         = bus.m_tready | ~r3_valid;
   assign bus.s_tready = w_en;

   assign w_p_rr = PW'(bus.b_re) * PW'(bus.w_re);
   assign w_p_ii = PW'(bus.b_im) * PW'(bus.w_im);
   assign w_p_ri = PW'(bus.b_re) * PW'(bus.w_im);
   assign w_p_ir = PW'(bus.b_im) * PW'(bus.w_re);

   // Rounded twiddle product; the arithmetic shift is the bit slice below
   assign w_rnd_re = SW'(r1_p_rr) - SW'(r1_p_ii) + c_RND;
   assign w_rnd_im = SW'(r1_p_ri) + SW'(r1_p_ir) + c_RND;

   assign w_x_re = XW'(r2_a_re) + XW'(r2_t_re);
   assign w_x_im = XW'(r2_a_im) + XW'(r2_t_im);
   assign w_y_re = XW'(r2_a_re) - XW'(r2_t_re);
   assign w_y_im = XW'(r2_a_im) - XW'(r2_t_im);

   assign w_px_re = f_post(w_x_re, r2_scale);
   assign w_px_im = f_post(w_x_im, r2_scale);
   assign w_py_re = f_post(w_y_re, r2_scale);
   assign w_py_im = f_post(w_y_im, r2_scale);

   assign w_sat = r2_valid &
                  (w_px_re[WIDTH] | w_px_im[WIDTH] | w_py_re[WIDTH] | w_py_im[WIDTH]);

   assign w_unused = ^{w_rnd_re[TW_WIDTH-2:0], w_rnd_re[SW-1],
                       w_rnd_im[TW_WIDTH-2:0], w_rnd_im[SW-1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1_valid <= 1'b0;
         r1_last  <= 1'b0;
         r1_scale <= 1'b0;
         r1_a_re  <= '0;
         r1_a_im  <= '0;
         r1_p_rr  <= '0;
         r1_p_ii  <= '0;
         r1_p_ri  <= '0;
         r1_p_ir  <= '0;
         r2_valid <= 1'b0;
         r2_last  <= 1'b0;
         r2_scale <= 1'b0;
         r2_a_re  <= '0;
         r2_a_im  <= '0;
         r2_t_re  <= '0;
         r2_t_im  <= '0;
         r3_valid <= 1'b0;
         r3_last  <= 1'b0;
         r3_x_re  <= '0;
         r3_x_im  <= '0;
         r3_y_re  <= '0;
         r3_y_im  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_en) begin
            r1_valid <= bus.s_tvalid;
            r1_last  <= bus.s_tvalid & bus.s_tlast;
            r1_scale <= bus.scale_i;
            r1_a_re  <= bus.a_re;
            r1_a_im  <= bus.a_im;
            r1_p_rr  <= w_p_rr;
            r1_p_ii  <= w_p_ii;
            r1_p_ri  <= w_p_ri;
            r1_p_ir  <= w_p_ir;

            r2_valid <= r1_valid;
            r2_last  <= r1_last;
            r2_scale <= r1_scale;
            r2_a_re  <= r1_a_re;
            r2_a_im  <= r1_a_im;
            r2_t_re  <= w_rnd_re[TW_WIDTH-1 +: WIDTH+1];
            r2_t_im  <= w_rnd_im[TW_WIDTH-1 +: WIDTH+1];

            r3_valid <= r2_valid;
            r3_last  <= r2_last;
            r3_x_re  <= w_px_re[WIDTH-1:0];
            r3_x_im  <= w_px_im[WIDTH-1:0];
            r3_y_re  <= w_py_re[WIDTH-1:0];
            r3_y_im  <= w_py_im[WIDTH-1:0];
         end
         // A saturating load outranks a coincident clear
         if (w_en && w_sat)
            r_ovf <= 1'b1;
         else if (bus.ovf_clr_i)
            r_ovf <= 1'b0;
      end
   end

   assign bus.m_tvalid = r3_valid;
   assign bus.m_tlast  = r3_last;
   assign bus.x_re     = r3_x_re;
   assign bus.x_im     = r3_x_im;
   assign bus.y_re     = r3_y_re;
   assign bus.y_im     = r3_y_im;
   assign bus.ovf_o    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_butterfly_stage_cplx.sv
`default_nettype none
// ============================================================================
// Module   : tb_butterfly_stage_cplx
// Purpose  : Directed bench for butterfly_stage_cplx against an integer model.
// Revision : 1.0
// ============================================================================
module tb_butterfly_stage_cplx;
   localparam int W  = 16;
   localparam int TW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   butterfly_stage_cplx_if #(.WIDTH(W), .TW_WIDTH(TW)) bus ();

   butterfly_stage_cplx #(.WIDTH(W), .TW_WIDTH(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      longint xr, xi, yr, yi;
      bit     last;
      bit     sat;
   } res_t;

   int   total = 0;
   int   bad   = 0;
   int   n_out = 0;
   res_t q[$];
   res_t e_m;
   res_t mref;
   bit   stall_prev = 1'b0;
   logic [4*W+1:0] held;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint wrap(input longint v, input int bits);
      longint m;
      m = longint'(1) << bits;
      v = v & (m - 1);
      if (v >= (m >>> 1)) v = v - m;
      return v;
   endfunction

   function automatic longint post(input longint v, input bit sc, inout bit sat);
      longint lim;
      lim = longint'(1) << (W - 1);
      if (sc) v = (v + 1) >>> 1;
      if (v > lim - 1) begin sat = 1'b1; return lim - 1; end
      if (v < -lim)    begin sat = 1'b1; return -lim;    end
      return v;
   endfunction

   function automatic res_t model(input longint ar, ai, br, bi, wr, wi,
                                  input bit sc, input bit last);
      res_t   r;
      longint tr, ti;
      bit     s;
      s  = 1'b0;
      tr = br * wr - bi * wi;
      ti = br * wi + bi * wr;
      tr = wrap((tr + (longint'(1) << (TW - 2))) >>> (TW - 1), W + 1);
      ti = wrap((ti + (longint'(1) << (TW - 2))) >>> (TW - 1), W + 1);
      r.xr   = post(ar + tr, sc, s);
      r.xi   = post(ai + ti, sc, s);
      r.yr   = post(ar - tr, sc, s);
      r.yi   = post(ai - ti, sc, s);
      r.sat  = s;
      r.last = last;
      return r;
   endfunction

   // Scoreboard: every accepted beat predicted, every transfer checked
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         stall_prev = 1'b0;
      end else begin
         chk("s_tready", longint'(bus.s_tready), longint'(bus.m_tready || !bus.m_tvalid));
         if (stall_prev)
            chk("stall_hold",
                longint'({bus.m_tvalid, bus.m_tlast, bus.x_re, bus.x_im, bus.y_re, bus.y_im} == held), 1);
         if (bus.m_tvalid && bus.m_tready) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: got beat x_re=%0d, expected no beat", bus.x_re);
            end else begin
               e_m = q.pop_front();
               chk("x_re", longint'(bus.x_re), e_m.xr);
               chk("x_im", longint'(bus.x_im), e_m.xi);
               chk("y_re", longint'(bus.y_re), e_m.yr);
               chk("y_im", longint'(bus.y_im), e_m.yi);
               chk("m_tlast", longint'(bus.m_tlast), longint'(e_m.last));
            end
            n_out++;
         end
         if (bus.m_tvalid && !bus.m_tready) begin
            held = {bus.m_tvalid, bus.m_tlast, bus.x_re, bus.x_im, bus.y_re, bus.y_im};
            stall_prev = 1'b1;
         end else begin
            stall_prev = 1'b0;
         end
         if (bus.s_tvalid && bus.s_tready)
            q.push_back(model(longint'(bus.a_re), longint'(bus.a_im),
                              longint'(bus.b_re), longint'(bus.b_im),
                              longint'(bus.w_re), longint'(bus.w_im),
                              bus.scale_i, bus.s_tlast));
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge
   task automatic drive(input int ar, ai, br, bi, wr, wi, input bit sc, input bit last);
      int n;
      n = 0;
      bus.a_re     = W'(ar);
      bus.a_im     = W'(ai);
      bus.b_re     = W'(br);
      bus.b_im     = W'(bi);
      bus.w_re     = TW'(wr);
      bus.w_im     = TW'(wi);
      bus.scale_i  = sc;
      bus.s_tlast  = last;
      bus.s_tvalid = 1'b1;
      @(negedge clk);
      while (!bus.s_tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.s_tready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got s_tready=0, expected 1 within 50 cycles");
      end
      @(posedge clk);
      #1;
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
   endtask

   task automatic check_out(input string name, input longint xr, xi, yr, yi);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!bus.m_tvalid && c < 20);
      chk({name, "_latency"}, c, 3);
      chk({name, "_x_re"}, longint'(bus.x_re), xr);
      chk({name, "_x_im"}, longint'(bus.x_im), xi);
      chk({name, "_y_re"}, longint'(bus.y_re), yr);
      chk({name, "_y_im"}, longint'(bus.y_im), yi);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish before 500000");
      $fatal(1);
   end

   initial begin
      int base;
      int t;
      rst = 1'b1;
      bus.s_tvalid  = 1'b0;
      bus.s_tlast   = 1'b0;
      bus.a_re      = '0;
      bus.a_im      = '0;
      bus.b_re      = '0;
      bus.b_im      = '0;
      bus.w_re      = '0;
      bus.w_im      = '0;
      bus.scale_i   = 1'b0;
      bus.m_tready  = 1'b1;
      bus.ovf_clr_i = 1'b0;

      // Pin the model with hand-computed results
      mref = model(2000, 0, 1000, 0, 32767, 0, 1'b0, 1'b0);
      chk("model_unity_xr", mref.xr, 3000);
      chk("model_unity_yr", mref.yr, 1000);
      mref = model(0, 0, 100, 200, 0, -32768, 1'b0, 1'b0);
      chk("model_mj_xi", mref.xi, -100);
      chk("model_mj_yr", mref.yr, -200);
      mref = model(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0);
      chk("model_sat_flag", longint'(mref.sat), 1);
      mref = model(32767, 0, 32767, 0, 32767, 0, 1'b1, 1'b0);
      chk("model_scale_sat_flag", longint'(mref.sat), 0);

      #13;
      chk("rst_m_tvalid", longint'(bus.m_tvalid), 0);
      chk("rst_m_tlast", longint'(bus.m_tlast), 0);
      chk("rst_x_re", longint'(bus.x_re), 0);
      chk("rst_y_im", longint'(bus.y_im), 0);
      chk("rst_ovf", longint'(bus.ovf_o), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      drive(2000, 0, 1000, 0, 32767, 0, 1'b0, 1'b0);
      check_out("unity", 3000, 0, 1000, 0);
      chk("unity_ovf", longint'(bus.ovf_o), 0);
      idle(4);

      drive(0, 0, 100, 200, 0, -32768, 1'b0, 1'b0);
      check_out("mj", 200, -100, -200, 100);
      idle(4);

      drive(32767, 0, 32767, 0, 32767, 0, 1'b1, 1'b0);
      check_out("sat_scaled", 32767, 0, 1, 0);
      chk("sat_scaled_ovf", longint'(bus.ovf_o), 0);
      idle(4);

      drive(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0);
      check_out("sat", 32767, 0, 1, 0);
      chk("sat_ovf", longint'(bus.ovf_o), 1);
      idle(5);
      chk("ovf_sticky", longint'(bus.ovf_o), 1);
      bus.ovf_clr_i = 1'b1;
      idle(1);
      bus.ovf_clr_i = 1'b0;
      chk("ovf_cleared", longint'(bus.ovf_o), 0);
      idle(4);

      // Clear coincides with the saturating beat landing in the output stage
      drive(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0);
      idle(1);
      bus.ovf_clr_i = 1'b1;
      idle(1);
      bus.ovf_clr_i = 1'b0;
      chk("race_align", longint'(bus.m_tvalid), 1);
      chk("ovf_race", longint'(bus.ovf_o), 1);
      idle(4);

      // Eight back-to-back beats, output stalled 5 cycles once beat 2 shows
      base = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++)
               drive(i * 1000 - 3000, i * 100, 500 + i * 37, -200 * i,
                     23170, -23170, i[0], (i == 7));
         end
         begin
            t = 0;
            while (n_out < base + 1 && t < 100) begin
               @(negedge clk);
               t++;
            end
            idle(1);
            bus.m_tready = 1'b0;
            idle(5);
            bus.m_tready = 1'b1;
         end
      join
      t = 0;
      while (n_out < base + 8 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("burst_count", n_out - base, 8);
      idle(4);

      // Reset with three beats in flight
      drive(100, 1, 200, 2, 32767, 0, 1'b0, 1'b0);
      drive(300, 3, 400, 4, 32767, 0, 1'b0, 1'b0);
      drive(500, 5, 600, 6, 32767, 0, 1'b0, 1'b0);
      chk("ovf_pre_rst", longint'(bus.ovf_o), 1);
      chk("valid_pre_rst", longint'(bus.m_tvalid), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_m_tvalid", longint'(bus.m_tvalid), 0);
      chk("midrst_x_re", longint'(bus.x_re), 0);
      chk("midrst_y_re", longint'(bus.y_re), 0);
      chk("midrst_ovf", longint'(bus.ovf_o), 0);
      idle(2);
      rst = 1'b0;
      idle(3);
      chk("post_rst_idle", longint'(bus.m_tvalid), 0);
      drive(-1234, 77, 300, -300, 32767, 0, 1'b0, 1'b1);
      chk("post_rst_last_pending", longint'(bus.m_tlast), 0);
      check_out("post_rst", -934, -223, -1534, 377);
      chk("post_rst_tlast", longint'(bus.m_tlast), 1);
      idle(6);

      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
